// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC fetch slice: opcodes, addressing-mode code,
// instruction field positions and the fetch FSM encoding.
package sisc_pkg;

    localparam logic [3:0] OP_NOOP   = 4'd0;
    localparam logic [3:0] OP_LOD    = 4'd1;
    localparam logic [3:0] OP_STR    = 4'd2;
    localparam logic [3:0] OP_SWP    = 4'd3;
    localparam logic [3:0] OP_BRA    = 4'd4;
    localparam logic [3:0] OP_BRR    = 4'd5;
    localparam logic [3:0] OP_BNE    = 4'd6;
    localparam logic [3:0] OP_BNR    = 4'd7;
    localparam logic [3:0] OP_ALU_OP = 4'd8;
    localparam logic [3:0] OP_HLT    = 4'd15;

    localparam logic [3:0] AM_IMM    = 4'd8;

    // Least-significant bit of each IR field.
    localparam int OPC_LSB = 28;
    localparam int MM_LSB  = 24;
    localparam int RD_LSB  = 20;
    localparam int RS_LSB  = 16;
    localparam int RT_LSB  = 12;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/sisc_pc_unit.sv
// Program counter with +1 incrementer, absolute/relative branch-target mux and
// a pending-branch latch for redirects that arrive while a fetch is in flight.
module sisc_pc_unit #(
    parameter int PC_W = 16
) (
    input  logic            clk,
    input  logic            rst_f,
    input  logic [15:0]     imm,
    input  logic            br_rel,
    input  logic            br_taken,
    input  logic            br_now,
    input  logic            br_latch,
    input  logic            complete,
    input  logic            abort,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] br_target
);

    logic            br_pend;
    logic [PC_W-1:0] pend_target;

    // Relative targets sign-extend the offset and wrap silently at PC_W bits.
    always_comb begin
        br_target = br_rel ? (pc + PC_W'($signed(imm))) : PC_W'(imm);
    end

    always_ff @(posedge clk) begin
        if (!rst_f) begin
            pc          <= '0;
            br_pend     <= 1'b0;
            pend_target <= '0;
        end else if (complete) begin
            // A redirect on the completion cycle itself is the latest one and wins.
            if (br_taken)     pc <= br_target;
            else if (br_pend) pc <= pend_target;
            else              pc <= pc + PC_W'(1);
            br_pend <= 1'b0;
        end else if (abort) begin
            br_pend <= 1'b0;
        end else if (br_now) begin
            pc <= br_target;
        end else if (br_latch) begin
            br_pend     <= 1'b1;
            pend_target <= br_target;
        end
    end

endmodule

// File: rtl/sisc_fetch.sv
// Instruction-fetch stage: owns IR, runs the req/ack fetch FSM with a wait
// timeout, and presents decoded IR fields to the control FSM.
module sisc_fetch
    import sisc_pkg::*;
#(
    parameter int PC_W     = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic            clk,
    input  logic            rst_f,
    input  logic            fetch_start,
    input  logic            br_taken,
    input  logic            br_rel,
    output logic            im_req,
    output logic [PC_W-1:0] im_addr,
    input  logic            im_ack,
    input  logic [31:0]     im_rdata,
    output logic            ir_valid,
    output logic            busy,
    output logic            halted,
    output logic            fetch_err,
    output logic [3:0]      opcode,
    output logic [3:0]      mm,
    output logic [3:0]      rd,
    output logic [3:0]      rs,
    output logic [3:0]      rt,
    output logic [15:0]     imm,
    output logic [PC_W-1:0] pc,
    output fetch_state_e    state_dbg
);

    // Handshake: im_req rises the cycle after fetch_start and holds with a
    // stable im_addr until a cycle with im_ack=1 (data taken that cycle) or the
    // wait limit; im_ack is ignored whenever im_req is low.

    fetch_state_e    state;
    logic [31:0]     ir;
    logic [7:0]      wait_cnt;
    logic [PC_W-1:0] br_target;
    logic            in_idle;
    logic            in_req;
    logic            wait_done;

    assign in_idle   = (state == ST_IDLE);
    assign in_req    = (state == ST_REQ);
    assign wait_done = (wait_cnt == 8'(MAX_WAIT));

    sisc_pc_unit #(.PC_W(PC_W)) u_pc (
        .clk       (clk),
        .rst_f     (rst_f),
        .imm       (imm),
        .br_rel    (br_rel),
        .br_taken  (br_taken),
        .br_now    (in_idle && br_taken),
        .br_latch  (in_req && br_taken),
        .complete  (in_req && im_ack),
        .abort     (in_req && !im_ack && wait_done),
        .pc        (pc),
        .br_target (br_target)
    );

    always_ff @(posedge clk) begin
        if (!rst_f) begin
            state     <= ST_IDLE;
            ir        <= '0;
            im_req    <= 1'b0;
            im_addr   <= '0;
            ir_valid  <= 1'b0;
            halted    <= 1'b0;
            fetch_err <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            ir_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fetch_start) begin
                        state    <= ST_REQ;
                        im_req   <= 1'b1;
                        im_addr  <= br_taken ? br_target : pc;
                        wait_cnt <= '0;
                    end
                end
                ST_REQ: begin
                    // An ack on the very cycle the limit is reached still succeeds.
                    if (im_ack) begin
                        ir       <= im_rdata;
                        ir_valid <= 1'b1;
                        im_req   <= 1'b0;
                        wait_cnt <= '0;
                        if (im_rdata[OPC_LSB +: 4] == OP_HLT) begin
                            state  <= ST_HALT;
                            halted <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (wait_done) begin
                        ir        <= '0;
                        ir_valid  <= 1'b1;
                        im_req    <= 1'b0;
                        fetch_err <= 1'b1;
                        wait_cnt  <= '0;
                        state     <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_HALT: begin
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = in_req;
    assign state_dbg = state;
    assign opcode    = ir[OPC_LSB +: 4];
    assign mm        = ir[MM_LSB  +: 4];
    assign rd        = ir[RD_LSB  +: 4];
    assign rs        = ir[RS_LSB  +: 4];
    assign rt        = ir[RT_LSB  +: 4];
    assign imm       = ir[IMM_LSB +: 16];

endmodule

// File: tb/tb_sisc_fetch.sv
// Directed bench for sisc_fetch: stimulus pushes expected IR/pc/flags into a
// queue, a negedge monitor pops and compares on every ir_valid pulse.
module tb_sisc_fetch;
    import sisc_pkg::*;

    localparam int PC_W     = 16;
    localparam int MAX_WAIT = 15;
    localparam int W        = 50;

    logic            clk = 1'b0;
    logic            rst_f;
    logic            fetch_start, br_taken, br_rel, im_ack;
    logic [31:0]     im_rdata;
    logic            im_req, ir_valid, busy, halted, fetch_err;
    logic [PC_W-1:0] im_addr, pc;
    logic [3:0]      opcode, mm, rd, rs, rt;
    logic [15:0]     imm;
    fetch_state_e    state_dbg;

    logic [W-1:0] exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    bit  exp_err = 1'b0;
    bit  prev_valid = 1'b0;

    sisc_fetch #(.PC_W(PC_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_f(rst_f), .fetch_start(fetch_start), .br_taken(br_taken),
        .br_rel(br_rel), .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack),
        .im_rdata(im_rdata), .ir_valid(ir_valid), .busy(busy), .halted(halted),
        .fetch_err(fetch_err), .opcode(opcode), .mm(mm), .rd(rd), .rs(rs), .rt(rt),
        .imm(imm), .pc(pc), .state_dbg(state_dbg)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_f = 1'b0;
        tick();
        tick();
        rst_f = 1'b1;
    endtask

    // Driver: one fetch. br_start asserts br_taken with fetch_start; br_at
    // asserts br_taken on that wait cycle of REQ (-1 for none).
    task automatic fetch(input logic [31:0] w, input int dly, input logic [15:0] exp_addr,
                         input logic [15:0] exp_pc, input bit br_start, input int br_at,
                         input bit rel);
        fetch_start = 1'b1;
        br_taken    = br_start;
        br_rel      = rel;
        tick();
        fetch_start = 1'b0;
        br_taken    = 1'b0;
        check("req_high", W'(im_req), W'(1));
        check("req_addr", W'(im_addr), W'(exp_addr));
        for (int i = 0; i < dly; i++) begin
            br_taken = (i == br_at);
            tick();
            br_taken = 1'b0;
        end
        check("addr_stable", W'(im_addr), W'(exp_addr));
        exp_q.push_back({w, exp_pc, exp_err, (w[31:28] == 4'hF)});
        im_ack   = 1'b1;
        im_rdata = w;
        tick();
        im_ack   = 1'b0;
        im_rdata = 32'hDEAD_BEEF;
        check("req_low", W'(im_req), W'(0));
    endtask

    task automatic branch(input bit rel, input logic [15:0] exp_pc);
        br_taken = 1'b1;
        br_rel   = rel;
        tick();
        br_taken = 1'b0;
        check("branch_pc", W'(pc), W'(exp_pc));
        check("branch_state", W'(state_dbg), W'(ST_IDLE));
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (ir_valid) begin
            if (prev_valid) begin
                n_vec++; n_err++;
                $display("FAIL ir_valid_pulse: got 2-cycle pulse expected 1");
            end
            if (exp_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_ir_valid: got opcode 0x%0h pc 0x%0h expected none", opcode, pc);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("ir_fields", {opcode, mm, rd, rs, imm, pc, fetch_err, halted}, e);
                check("rt_field", W'(rt), W'(e[W-1-16 -: 4]));
            end
        end
        prev_valid = ir_valid;
    end

    initial begin
        int cnt;
        rst_f = 1'b0; fetch_start = 1'b0; br_taken = 1'b0; br_rel = 1'b0;
        im_ack = 1'b0; im_rdata = 32'h0;
        do_reset();

        check("rst_pc", W'(pc), W'(0));
        check("rst_req", W'({im_req, im_addr}), W'(0));
        check("rst_flags", W'({ir_valid, busy, halted, fetch_err}), W'(0));
        check("rst_ir", W'({opcode, imm}), W'(0));
        check("rst_state", W'(state_dbg), W'(ST_IDLE));

        // Basic fetch, ack after 2 wait cycles
        fetch(32'h1A23_4005, 2, 16'h0000, 16'h0001, 0, -1, 0);
        check("idle_after", W'({busy, state_dbg}), W'({1'b0, ST_IDLE}));

        // Absolute branch to 0x000F, fetch imm=0xFFFC there, then relative -4
        fetch(32'h0000_000F, 0, 16'h0001, 16'h0002, 0, -1, 0);
        branch(0, 16'h000F);
        fetch(32'h0000_FFFC, 1, 16'h000F, 16'h0010, 0, -1, 0);
        branch(1, 16'h000C);
        fetch(32'h0000_0040, 0, 16'h000C, 16'h000D, 0, -1, 0);
        branch(0, 16'h0040);

        // Branch while in REQ: applied at completion instead of pc+1
        fetch(32'h0000_0100, 0, 16'h0040, 16'h0041, 0, -1, 0);
        fetch(32'h8123_0007, 3, 16'h0041, 16'h0100, 0, 1, 0);
        fetch(32'h2456_0200, 1, 16'h0100, 16'h0101, 0, -1, 0);

        // fetch_start with br_taken in IDLE: fetch from the new target
        fetch(32'h3789_0000, 0, 16'h0200, 16'h0201, 1, -1, 0);

        // Timeout: no ack
        exp_err = 1'b1;
        exp_q.push_back({32'h0, 16'h0201, 1'b1, 1'b0});
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        cnt = 0;
        while (im_req && cnt < 40) begin
            cnt++;
            tick();
        end
        check("timeout_cycles", W'(cnt), W'(MAX_WAIT + 1));
        check("timeout_flags", W'({im_req, fetch_err, opcode}), W'({1'b0, 1'b1, 4'h0}));
        check("timeout_pc", W'(pc), W'(16'h0201));
        tick();

        // Ack exactly at the wait limit still succeeds; fetch_err stays sticky
        fetch(32'h3789_0000, MAX_WAIT, 16'h0201, 16'h0202, 0, -1, 0);

        // pc wrap at 0xFFFF
        fetch(32'h0000_FFFF, 0, 16'h0202, 16'h0203, 0, -1, 0);
        branch(0, 16'hFFFF);
        fetch(32'h1000_0001, 0, 16'hFFFF, 16'h0000, 0, -1, 0);

        // HLT: frozen thereafter, late/stray ack ignored
        fetch(32'hF000_0000, 0, 16'h0000, 16'h0001, 0, -1, 0);
        check("halt_state", W'({halted, state_dbg}), W'({1'b1, ST_HALT}));
        fetch_start = 1'b1; br_taken = 1'b1; br_rel = 1'b0;
        im_ack = 1'b1; im_rdata = 32'h1234_5678;
        tick(); tick(); tick();
        fetch_start = 1'b0; br_taken = 1'b0; im_ack = 1'b0;
        check("halt_noreq", W'(im_req), W'(0));
        check("halt_pc", W'(pc), W'(16'h0001));
        check("halt_ir", W'({opcode, imm}), W'({4'hF, 16'h0000}));

        // Reset mid-REQ, then a late ack
        do_reset();
        exp_err = 1'b0;
        check("rst2_flags", W'({halted, fetch_err, state_dbg}), W'({1'b0, 1'b0, ST_IDLE}));
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        check("mid_req", W'(im_req), W'(1));
        rst_f = 1'b0;
        tick();
        rst_f = 1'b1;
        check("rst_abandon", W'(im_req), W'(0));
        im_ack = 1'b1; im_rdata = 32'h1111_1111;
        tick();
        im_ack = 1'b0;
        tick();
        check("late_ack_ir", W'({opcode, imm}), W'(0));
        check("late_ack_pc", W'(pc), W'(0));

        tick();
        check("queue_empty", W'(exp_q.size()), W'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
